// File: rtl/exception_trap_sequencer_pkg.sv
// Shared constants for the trap sequencer: exception codes, FSM states, sizing helper.
package exception_trap_sequencer_pkg;

  // RISC-V synchronous exception causes (4-bit slice of mcause)
  localparam logic [3:0] E_FETCH_ADDR_MISALIGNED = 4'd0;
  localparam logic [3:0] E_FETCH_ACCESS_FAULT    = 4'd1;
  localparam logic [3:0] E_ILLEGAL_INSTR         = 4'd2;
  localparam logic [3:0] E_BREAKPOINT            = 4'd3;
  localparam logic [3:0] E_LOAD_ADDR_MISALIGNED  = 4'd4;
  localparam logic [3:0] E_LOAD_ACCESS_FAULT     = 4'd5;
  localparam logic [3:0] E_STORE_ADDR_MISALIGNED = 4'd6;
  localparam logic [3:0] E_STORE_ACCESS_FAULT    = 4'd7;
  localparam logic [3:0] E_ECALL                 = 4'd11;
  // Reserved cause value reused as "no exception"
  localparam logic [3:0] NO_E                    = 4'd14;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_REQ,
    ST_REDIRECT,
    ST_LOCKED
  } trap_state_e;

  // Index width that stays legal for a single stage
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/exception_trap_sequencer_exc_oldest_sel.sv
// Combinational picker: the highest-index (oldest) stage with a live exception.
module exc_oldest_sel
  import exception_trap_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int NUM_STAGES = 2,
  parameter int IDX_W      = idx_width(NUM_STAGES)
) (
  input  logic [4*NUM_STAGES-1:0]    exc_code,
  input  logic [XLEN*NUM_STAGES-1:0] exc_pc,
  input  logic [XLEN*NUM_STAGES-1:0] exc_tval,
  output logic                       valid,
  output logic [IDX_W-1:0]           idx,
  output logic [3:0]                 code,
  output logic [XLEN-1:0]            pc,
  output logic [XLEN-1:0]            tval
);

  // Ascending scan; later (older) stages overwrite earlier hits
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    code  = NO_E;
    pc    = '0;
    tval  = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (exc_code[4*s +: 4] != NO_E) begin
        valid = 1'b1;
        idx   = IDX_W'(s);
        code  = exc_code[4*s +: 4];
        pc    = exc_pc[XLEN*s +: XLEN];
        tval  = exc_tval[XLEN*s +: XLEN];
      end
    end
  end

endmodule

// File: rtl/exception_trap_sequencer.sv
// Trap sequencer: capture oldest exception, flush, CSR handshake, redirect, lock on fault.
module exception_trap_sequencer
  import exception_trap_sequencer_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              NUM_STAGES  = 2,
  parameter logic [XLEN-1:0] TRAP_VEC    = '0,
  parameter int              ACK_TIMEOUT = 15,
  parameter int              CNT_W       = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_stall,
  input  logic [4*NUM_STAGES-1:0]    i_exc_code,
  input  logic [XLEN*NUM_STAGES-1:0] i_exc_pc,
  input  logic [XLEN*NUM_STAGES-1:0] i_exc_tval,
  input  logic                       i_in_trap,
  input  logic                       i_trap_ack,
  output logic [NUM_STAGES-1:0]      o_flush,
  output logic                       o_trap_req,
  output logic [3:0]                 o_mcause,
  output logic [XLEN-1:0]            o_mepc,
  output logic [XLEN-1:0]            o_mtval,
  output logic                       o_pc_redirect,
  output logic [XLEN-1:0]            o_redirect_target,
  output logic                       o_locked,
  output logic [CNT_W-1:0]           o_trap_count
);

  localparam int IDX_W = idx_width(NUM_STAGES);
  // Counter only needs to reach ACK_TIMEOUT-1: the last silent cycle locks
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  trap_state_e             state;
  logic [TO_W-1:0]         to_cnt;
  logic                    sel_valid;
  logic [IDX_W-1:0]        sel_idx;
  logic [3:0]              sel_code;
  logic [XLEN-1:0]         sel_pc;
  logic [XLEN-1:0]         sel_tval;
  logic [NUM_STAGES-1:0]   sel_mask;

  exc_oldest_sel #(
    .XLEN       (XLEN),
    .NUM_STAGES (NUM_STAGES),
    .IDX_W      (IDX_W)
  ) u_sel (
    .exc_code (i_exc_code),
    .exc_pc   (i_exc_pc),
    .exc_tval (i_exc_tval),
    .valid    (sel_valid),
    .idx      (sel_idx),
    .code     (sel_code),
    .pc       (sel_pc),
    .tval     (sel_tval)
  );

  // Flush the winning stage and everything younger than it
  always_comb begin
    sel_mask = '0;
    for (int s = 0; s < NUM_STAGES; s++)
      sel_mask[s] = (s <= int'(sel_idx));
  end

  // Sequencer FSM with registered outputs and capture registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state             <= ST_IDLE;
      to_cnt            <= '0;
      o_flush           <= '0;
      o_trap_req        <= 1'b0;
      o_mcause          <= '0;
      o_mepc            <= '0;
      o_mtval           <= '0;
      o_pc_redirect     <= 1'b0;
      o_redirect_target <= '0;
      o_locked          <= 1'b0;
      o_trap_count      <= '0;
    end else begin
      o_pc_redirect     <= 1'b0;
      o_redirect_target <= '0;
      case (state)
        ST_IDLE: begin
          if (!i_stall && sel_valid) begin
            o_mcause <= sel_code;
            o_mepc   <= sel_pc;
            o_mtval  <= sel_tval;
            if (i_in_trap) begin
              state    <= ST_LOCKED;
              o_locked <= 1'b1;
              o_flush  <= '1;
            end else begin
              state   <= ST_FLUSH;
              o_flush <= sel_mask;
            end
          end
        end
        ST_FLUSH: begin
          state      <= ST_REQ;
          o_flush    <= '1;
          o_trap_req <= 1'b1;
          to_cnt     <= '0;
        end
        ST_REQ: begin
          // Ack is checked first so it wins over a coincident timeout
          if (i_trap_ack) begin
            state             <= ST_REDIRECT;
            o_trap_req        <= 1'b0;
            o_flush           <= '0;
            o_pc_redirect     <= 1'b1;
            o_redirect_target <= TRAP_VEC;
            if (o_trap_count != '1)
              o_trap_count <= o_trap_count + CNT_W'(1);
          end else if (to_cnt == TO_W'(ACK_TIMEOUT - 1)) begin
            state      <= ST_LOCKED;
            o_trap_req <= 1'b0;
            o_locked   <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        ST_REDIRECT: state <= ST_IDLE;
        ST_LOCKED:   state <= ST_LOCKED;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule
